la_cmd_loader: RTL and testbench
================================

Name: la_cmd_loader

Overview:
- Host-to-analyzer command path: the inbound counterpart of the capture-dump UART stream.
- Consumes bytes from the UART receiver (rxout/rxrdy) and assembles 16-byte, MSB-first words into the logic analyzer trigger registers (low/high/rising/falling).
- Issues the analyzer reset/re-arm pulse on command.
- Sits between UART and RedTinLogicAnalyzer in the hardware testbench. Replaces the hard-wired trigger constants.

Parameters:
- WIDTH, 128: trigger word width in bits; must be a multiple of 8; NBYTES = WIDTH/8.
- TIMEOUT_CYCLES, 200000: max idle clocks between bytes inside a frame (10 ms at 20 MHz).

Ports:
- clk  in  1  system clock (20 MHz domain, same as analyzer and UART)
- reset_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte (UART rxout)
- rx_rdy  in  1  one-cycle strobe: rx_data valid (UART rxrdy)
- rx_overflow  in  1  UART overflow flag
- trigger_low  out  WIDTH  committed trigger-low mask
- trigger_high  out  WIDTH  committed trigger-high mask
- trigger_rising  out  WIDTH  committed rising-edge mask
- trigger_falling  out  WIDTH  committed falling-edge mask
- la_reset  out  1  one-cycle pulse to the analyzer reset input
- cmd_ok  out  1  one-cycle pulse: frame accepted
- cmd_err  out  1  one-cycle pulse: frame rejected
- err_code  out  2  cause of last error; held until the next cmd_err

Behaviour:
- Reset (reset_n low, async): all trigger outputs 0, la_reset/cmd_ok/cmd_err 0, err_code 0, FSM IDLE, staging register 0, byte counter 0, timeout counter 0.
- Frame format: OPCODE, then payload, then CHK. CHK = XOR of OPCODE and all payload bytes.
- Opcodes:
  - 0x01 low, 0x02 high, 0x03 rising, 0x04 falling: each carries NBYTES payload.
  - 0x10 re-arm: no payload.
- Payload byte 0 maps to [WIDTH-1:WIDTH-8]; the last byte maps to [7:0].
- FSM states: IDLE, PAYLOAD, CHECK.
- IDLE, on rx_rdy:
  - Write opcode: latch opcode, running XOR = byte, count = 0, go to PAYLOAD.
  - 0x10: latch, XOR = byte, go to CHECK.
  - Other value: cmd_err pulse, err_code = 1, stay IDLE.
- PAYLOAD, on rx_rdy:
  - Shift the byte into the staging register from the LSB side (staging <= {staging[WIDTH-9:0], byte}); XOR it in; count++.
  - When count reaches NBYTES-1 on a strobe, go to CHECK.
- CHECK, on rx_rdy:
  - Byte equals XOR: commit. Staging goes to the selected trigger register, or la_reset pulses for 0x10. cmd_ok pulses. Go to IDLE.
  - Mismatch: cmd_err pulses, err_code = 2, no register change, go to IDLE.
- Latency: commit, cmd_ok, cmd_err and la_reset are all registered. They are visible the clock after the CHK strobe and last exactly one cycle.
- Atomicity: trigger outputs change only on commit, never mid-frame.
- Timeout:
  - In PAYLOAD/CHECK, the counter increments every cycle without rx_rdy and clears on rx_rdy.
  - Reaching TIMEOUT_CYCLES-1: cmd_err, err_code = 3, go to IDLE, staging discarded.
  - Counter held at 0 in IDLE.
- Overflow: rx_overflow high in any non-IDLE state aborts with cmd_err, err_code = 0, to IDLE. Overflow takes priority over a simultaneous rx_rdy. In IDLE, overflow is ignored.
- The next opcode is accepted the cycle immediately after CHK; back-to-back frames need no gap.
- Async reset mid-frame: everything returns to reset values, including committed trigger registers.

Decomposition:
- Shared package (la_cmd_pkg): opcode constants (OP_WR_LOW=0x01, OP_WR_HIGH=0x02, OP_WR_RISING=0x03, OP_WR_FALLING=0x04, OP_REARM=0x10), error codes (ERR_OVERFLOW=0, ERR_OPCODE=1, ERR_CHECKSUM=2, ERR_TIMEOUT=3), and state encoding.
- One natural sub-module: la_cmd_timeout, the inter-byte watchdog counter with clear/enable and an expiry pulse.
- The datapath (staging shift register, XOR, register bank) stays in the top.

Test Plan:
- Frame 0x03, 0x00×15, 0x01, CHK=0x02:
  - The cycle after CHK, trigger_rising = 128'h1 and cmd_ok pulses once.
  - Other trigger registers remain 0.
- Frame 0x01 with payload 0x80,0x00×15 and CHK=0x00 (wrong; correct is 0x81):
  - cmd_err pulses, err_code = 2, trigger_low unchanged (0).
- Byte 0x10, then 0x10:
  - la_reset pulses for exactly one cycle and cmd_ok pulses.
  - Stray byte 0x55 in IDLE gives cmd_err, err_code = 1, with no state change.
- With TIMEOUT_CYCLES=100: send 0x02 plus 5 payload bytes, then idle 100 cycles:
  - cmd_err, err_code = 3.
  - A following complete valid 0x02 frame commits correctly, proving the counter and staging reset.
- Assert rx_overflow on the same cycle as payload byte 8 of a 0x04 frame:
  - cmd_err, err_code = 0, trigger_falling unchanged.
- Two back-to-back frames with zero gap (0x01 all-0xFF, then 0x02 all-0xAA):
  - Both commit, two cmd_ok pulses.
  - Assert reset_n low mid-second-frame: all outputs 0 asynchronously.

Source files
------------

// File: rtl/la_cmd_pkg.sv
// Shared constants for the host command loader: opcodes, error codes and FSM encoding.
package la_cmd_pkg;

    localparam logic [7:0] OP_WR_LOW     = 8'h01;
    localparam logic [7:0] OP_WR_HIGH    = 8'h02;
    localparam logic [7:0] OP_WR_RISING  = 8'h03;
    localparam logic [7:0] OP_WR_FALLING = 8'h04;
    localparam logic [7:0] OP_REARM      = 8'h10;

    localparam logic [1:0] ERR_OVERFLOW = 2'd0;
    localparam logic [1:0] ERR_OPCODE   = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_WR_LOW) || (op == OP_WR_HIGH) ||
               (op == OP_WR_RISING) || (op == OP_WR_FALLING);
    endfunction

endpackage

// File: rtl/la_cmd_loader_if.sv
// Byte stream from the UART receiver into the command loader.
interface la_cmd_loader_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_overflow;

    modport master (output rx_data, output rx_rdy, output rx_overflow);
    modport slave  (input  rx_data, input  rx_rdy, input  rx_overflow);
endinterface

// File: rtl/la_cmd_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open, pulses expire_o on the last one.
module la_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = run_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/la_cmd_loader.sv
// Assembles checksummed UART command frames into the analyzer trigger masks and issues re-arm pulses.
module la_cmd_loader
    import la_cmd_pkg::*;
#(
    parameter int WIDTH          = 128,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic             clk,
    input  logic             reset_n,
    la_cmd_loader_if.slave   rx,
    output logic [WIDTH-1:0] trigger_low,
    output logic [WIDTH-1:0] trigger_high,
    output logic [WIDTH-1:0] trigger_rising,
    output logic [WIDTH-1:0] trigger_falling,
    output logic             la_reset,
    output logic             cmd_ok,
    output logic             cmd_err,
    output logic [1:0]       err_code
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CNTW   = $clog2(NBYTES + 1);

    state_e           state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [7:0]       xor_q, xor_d;
    logic [WIDTH-1:0] staging_q, staging_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] trig_q [4];
    logic [3:0]       wr_en;
    logic             la_reset_q, la_reset_d;
    logic             cmd_ok_q, cmd_ok_d;
    logic             cmd_err_q, cmd_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             expire;
    logic             ovf_abort;

    // Overflow only matters once a frame is open, and it beats a simultaneous byte.
    assign ovf_abort = rx.rx_overflow && (state_q != ST_IDLE);

    la_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .run_i    (state_q != ST_IDLE),
        .clr_i    (rx.rx_rdy || rx.rx_overflow),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx.rx_rdy) begin
                    if (is_write_op(rx.rx_data))     state_d = ST_PAYLOAD;
                    else if (rx.rx_data == OP_REARM) state_d = ST_CHECK;
                end
            end
            ST_PAYLOAD: begin
                if (ovf_abort)                                          state_d = ST_IDLE;
                else if (rx.rx_rdy && count_q == CNTW'(NBYTES - 1))     state_d = ST_CHECK;
                else if (expire)                                        state_d = ST_IDLE;
            end
            ST_CHECK: begin
                if (ovf_abort || rx.rx_rdy || expire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        opcode_d   = opcode_q;
        xor_d      = xor_q;
        staging_d  = staging_q;
        count_d    = count_q;
        wr_en      = '0;
        la_reset_d = 1'b0;
        cmd_ok_d   = 1'b0;
        cmd_err_d  = 1'b0;
        err_code_d = err_code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx.rx_rdy) begin
                    if (is_write_op(rx.rx_data) || rx.rx_data == OP_REARM) begin
                        opcode_d  = rx.rx_data;
                        xor_d     = rx.rx_data;
                        count_d   = '0;
                        staging_d = '0;
                    end else begin
                        cmd_err_d  = 1'b1;
                        err_code_d = ERR_OPCODE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (ovf_abort) begin
                    cmd_err_d  = 1'b1;
                    err_code_d = ERR_OVERFLOW;
                    staging_d  = '0;
                end else if (rx.rx_rdy) begin
                    staging_d = {staging_q[WIDTH-9:0], rx.rx_data};
                    xor_d     = xor_q ^ rx.rx_data;
                    count_d   = count_q + CNTW'(1);
                end else if (expire) begin
                    cmd_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    staging_d  = '0;
                end
            end
            ST_CHECK: begin
                if (ovf_abort) begin
                    cmd_err_d  = 1'b1;
                    err_code_d = ERR_OVERFLOW;
                    staging_d  = '0;
                end else if (rx.rx_rdy) begin
                    if (rx.rx_data == xor_q) begin
                        cmd_ok_d = 1'b1;
                        unique case (opcode_q)
                            OP_WR_LOW:     wr_en[0] = 1'b1;
                            OP_WR_HIGH:    wr_en[1] = 1'b1;
                            OP_WR_RISING:  wr_en[2] = 1'b1;
                            OP_WR_FALLING: wr_en[3] = 1'b1;
                            default:       la_reset_d = 1'b1;
                        endcase
                    end else begin
                        cmd_err_d  = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end else if (expire) begin
                    cmd_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    staging_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q   <= '0;
            xor_q      <= '0;
            staging_q  <= '0;
            count_q    <= '0;
            la_reset_q <= 1'b0;
            cmd_ok_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            err_code_q <= '0;
            for (int i = 0; i < 4; i++) trig_q[i] <= '0;
        end else begin
            opcode_q   <= opcode_d;
            xor_q      <= xor_d;
            staging_q  <= staging_d;
            count_q    <= count_d;
            la_reset_q <= la_reset_d;
            cmd_ok_q   <= cmd_ok_d;
            cmd_err_q  <= cmd_err_d;
            err_code_q <= err_code_d;
            for (int i = 0; i < 4; i++) begin
                if (wr_en[i]) trig_q[i] <= staging_q;
            end
        end
    end

    assign trigger_low     = trig_q[0];
    assign trigger_high    = trig_q[1];
    assign trigger_rising  = trig_q[2];
    assign trigger_falling = trig_q[3];
    assign la_reset        = la_reset_q;
    assign cmd_ok          = cmd_ok_q;
    assign cmd_err         = cmd_err_q;
    assign err_code        = err_code_q;

endmodule

// File: tb/tb_la_cmd_loader.sv
// Directed scenario bench for la_cmd_loader (WIDTH=128, TIMEOUT_CYCLES=100).
module tb_la_cmd_loader;
    localparam int WIDTH = 128;
    localparam int TMO   = 100;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] trigger_low, trigger_high, trigger_rising, trigger_falling;
    logic             la_reset, cmd_ok, cmd_err;
    logic [1:0]       err_code;

    int errors = 0;
    int checks = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int lar_cnt = 0;

    la_cmd_loader_if rx_if ();

    la_cmd_loader #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx              (rx_if.slave),
        .trigger_low     (trigger_low),
        .trigger_high    (trigger_high),
        .trigger_rising  (trigger_rising),
        .trigger_falling (trigger_falling),
        .la_reset        (la_reset),
        .cmd_ok          (cmd_ok),
        .cmd_err         (cmd_err),
        .err_code        (err_code)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled at the active edge, i.e. the value held through the previous cycle.
    always @(posedge clk) begin
        if (cmd_ok)   ok_cnt++;
        if (cmd_err)  err_cnt++;
        if (la_reset) lar_cnt++;
    end

    // Called on a negedge; returns on the next negedge, after the DUT sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_data = b;
        rx_if.rx_rdy  = 1'b1;
        @(negedge clk);
        rx_if.rx_rdy  = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH/8 - 1; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic test_reset;
        rx_if.rx_data = 8'h00;
        rx_if.rx_rdy = 1'b0;
        rx_if.rx_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({trigger_low, trigger_high, trigger_rising, trigger_falling} !== '0) begin
            errors++;
            $display("FAIL reset_triggers: got nonzero, expected 0");
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({la_reset, cmd_ok, cmd_err, err_code} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {la_reset, cmd_ok, cmd_err, err_code});
        end
    endtask

    task automatic test_write_rising;
        send_byte(8'h03);
        send_word(128'h1);
        send_byte(8'h02);
        checks++;
        if (trigger_rising !== 128'h1 || cmd_ok !== 1'b1) begin
            errors++;
            $display("FAIL rising_commit: got rising=%h ok=%b expected rising=1 ok=1", trigger_rising, cmd_ok);
        end
        checks++;
        if ({trigger_low, trigger_high, trigger_falling} !== '0) begin
            errors++;
            $display("FAIL rising_others: got low=%h high=%h fall=%h expected 0", trigger_low, trigger_high, trigger_falling);
        end
        @(negedge clk);
        checks++;
        if (cmd_ok !== 1'b0) begin
            errors++;
            $display("FAIL rising_ok_width: got cmd_ok=%b expected 0", cmd_ok);
        end
    endtask

    task automatic test_bad_checksum;
        send_byte(8'h01);
        send_word({8'h80, 120'h0});
        send_byte(8'h00);
        checks++;
        if (cmd_err !== 1'b1 || err_code !== 2'd2 || cmd_ok !== 1'b0) begin
            errors++;
            $display("FAIL chk_err: got err=%b code=%0d ok=%b expected err=1 code=2 ok=0", cmd_err, err_code, cmd_ok);
        end
        checks++;
        if (trigger_low !== '0) begin
            errors++;
            $display("FAIL chk_low_kept: got %h expected 0", trigger_low);
        end
        @(negedge clk);
    endtask

    task automatic test_rearm_and_stray;
        int base_lar;
        base_lar = lar_cnt;
        send_byte(8'h10);
        send_byte(8'h10);
        checks++;
        if (la_reset !== 1'b1 || cmd_ok !== 1'b1) begin
            errors++;
            $display("FAIL rearm_pulse: got la_reset=%b ok=%b expected 1 1", la_reset, cmd_ok);
        end
        @(negedge clk);
        checks++;
        if (lar_cnt - base_lar !== 1 || la_reset !== 1'b0) begin
            errors++;
            $display("FAIL rearm_width: got %0d cycles expected 1", lar_cnt - base_lar);
        end
        send_byte(8'h55);
        checks++;
        if (cmd_err !== 1'b1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL stray_opcode: got err=%b code=%0d expected err=1 code=1", cmd_err, err_code);
        end
        checks++;
        if (trigger_rising !== 128'h1 || trigger_low !== '0) begin
            errors++;
            $display("FAIL stray_no_change: got rising=%h low=%h expected 1 and 0", trigger_rising, trigger_low);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int waited;
        logic seen;
        seen = 1'b0;
        waited = 0;
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        while (!seen && waited < 150) begin
            @(negedge clk);
            waited++;
            if (cmd_err === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || waited !== TMO || err_code !== 2'd3) begin
            errors++;
            $display("FAIL timeout_err: got seen=%b after %0d cycles code=%0d expected %0d cycles code=3", seen, waited, err_code, TMO);
        end
        checks++;
        if (trigger_high !== '0) begin
            errors++;
            $display("FAIL timeout_high_kept: got %h expected 0", trigger_high);
        end
        @(negedge clk);
        send_byte(8'h02);
        send_word(128'h000102030405060708090a0b0c0d0e0f);
        send_byte(8'h02);
        checks++;
        if (cmd_ok !== 1'b1 || trigger_high !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++;
            $display("FAIL timeout_recover: got ok=%b high=%h expected ok=1 high=000102030405060708090a0b0c0d0e0f", cmd_ok, trigger_high);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        send_byte(8'h04);
        for (int i = 0; i < 8; i++) send_byte(8'hF0);
        rx_if.rx_overflow = 1'b1;
        send_byte(8'hF0);
        rx_if.rx_overflow = 1'b0;
        checks++;
        if (cmd_err !== 1'b1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL overflow_err: got err=%b code=%0d expected err=1 code=0", cmd_err, err_code);
        end
        checks++;
        if (trigger_falling !== '0) begin
            errors++;
            $display("FAIL overflow_fall_kept: got %h expected 0", trigger_falling);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int base_ok;
        base_ok = ok_cnt;
        send_byte(8'h01);
        send_word({16{8'hFF}});
        send_byte(8'h01);
        send_byte(8'h02);
        send_word({16{8'hAA}});
        send_byte(8'h02);
        @(negedge clk);
        checks++;
        if (ok_cnt - base_ok !== 2) begin
            errors++;
            $display("FAIL b2b_ok_count: got %0d pulses expected 2", ok_cnt - base_ok);
        end
        checks++;
        if (trigger_low !== {16{8'hFF}} || trigger_high !== {16{8'hAA}}) begin
            errors++;
            $display("FAIL b2b_values: got low=%h high=%h expected all FF and all AA", trigger_low, trigger_high);
        end
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) send_byte(8'h33);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({trigger_low, trigger_high, trigger_rising, trigger_falling} !== '0 ||
            {la_reset, cmd_ok, cmd_err, err_code} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got low=%h high=%h flags=%b expected all 0", trigger_low, trigger_high, {la_reset, cmd_ok, cmd_err, err_code});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_rising();
        test_bad_checksum();
        test_rearm_and_stray();
        test_timeout();
        test_overflow();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
